avalon_io_wb16_bridge: RTL

//  - Converts the ao486 32-bit Avalon I/O master port into 16-bit Wishbone classic master cycles.
//  - Drives the wb_intercon I/O slaves (post, uart, future PIC/PIT).
//  - Sits directly between the ao486 avalon_io_* pins and the wb_*_io bus.
//  - Splits each dword-lane access into at most two 16-bit cycles: low half first, then high half.
//  - Reassembles read data into one readdatavalid beat.

---
 rtl/ao486_io_pkg.sv | 29 ++
 rtl/io_bus_timer.sv | 29 ++
 rtl/avalon_io_wb16_bridge.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ao486_io_pkg.sv
// Shared types and helpers for the ao486 Avalon I/O to 16-bit Wishbone bridge.
package ao486_io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RESP = 2'd3
    } io_state_t;

    // Value an unanswered ISA read returns: the bus floats high.
    localparam logic [15:0] IO_FLOAT_DATA = 16'hFFFF;

    typedef struct packed {
        logic        rd;
        logic [13:0] dw;
        logic [3:0]  be;
        logic [31:0] wd;
    } io_cmd_t;

    function automatic logic lo_lane_en(input logic [3:0] be);
        return |be[1:0];
    endfunction

    function automatic logic hi_lane_en(input logic [3:0] be);
        return |be[3:2];
    endfunction

endpackage

// File: rtl/io_bus_timer.sv
// Purpose: watchdog counting cycles of an open Wishbone cycle.
// Latency: expired rises in the LIMIT-th cycle of run.
// Backpressure: none; clr or a low run restarts the count.
module io_bus_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int W = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr || !run) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = run & (cnt_q == LAST);

endmodule

// File: rtl/avalon_io_wb16_bridge.sv
// Purpose: ao486 32-bit Avalon I/O port to 16-bit Wishbone classic master, low half first.
// Latency: both-half zero-wait read accepted at T0 returns readdatavalid sampled at T5.
// Backpressure: waitrequest held until IDLE; WB_IO_TIMEOUT_EN adds a cycle watchdog.
module avalon_io_wb16_bridge
    import ao486_io_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [15:0] avs_address,
    input  logic [3:0]  avs_byteenable,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic        avs_waitrequest,
    output logic [14:0] wbm_adr_o,
    output logic [15:0] wbm_dat_o,
    output logic [1:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic [15:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    io_state_t   state_q, state_d;
    io_cmd_t     cmd_q;
    logic [31:0] rd_q;
    logic        cyc_q, we_q;
    logic [14:0] adr_q;
    logic [15:0] dat_q;
    logic [1:0]  sel_q;
    logic        accept, launch, term, term_err, bus_timeout;
    logic [15:0] cap_dat;
    logic        unused_bits;

    assign unused_bits = ^{avs_address[1:0], TIMEOUT_CYCLES[0]};

`ifdef WB_IO_TIMEOUT_EN
    io_bus_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clr     (term),
        .run     (cyc_q),
        .expired (bus_timeout)
    );
`else
    assign bus_timeout = 1'b0;
`endif

    assign accept   = (state_q == ST_IDLE) & (avs_read | avs_write);
    assign launch   = ((state_q == ST_LO) | (state_q == ST_HI)) & ~cyc_q;
    // A watchdog expiry or err (even alongside ack) ends the half as a floating read.
    assign term     = cyc_q & (wbm_ack_i | wbm_err_i | bus_timeout);
    assign term_err = cyc_q & (wbm_err_i | bus_timeout);
    assign cap_dat  = term_err ? IO_FLOAT_DATA : wbm_dat_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (lo_lane_en(avs_byteenable))      state_d = ST_LO;
                    else if (hi_lane_en(avs_byteenable)) state_d = ST_HI;
                    else if (avs_read)                   state_d = ST_RESP;
                end
            end
            ST_LO: begin
                if (term) begin
                    if (hi_lane_en(cmd_q.be)) state_d = ST_HI;
                    else if (cmd_q.rd)        state_d = ST_RESP;
                    else                      state_d = ST_IDLE;
                end
            end
            ST_HI: begin
                if (term) state_d = cmd_q.rd ? ST_RESP : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus outputs are registered, so each half launches one cycle after entering LO/HI.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cmd_q <= '0;
            rd_q  <= '0;
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
            sel_q <= '0;
        end else begin
            if (accept) begin
                cmd_q <= '{rd: avs_read, dw: avs_address[15:2],
                           be: avs_byteenable, wd: avs_writedata};
                rd_q  <= '0;
            end
            if (term) begin
                cyc_q <= 1'b0;
                if (state_q == ST_HI) rd_q[31:16] <= cap_dat;
                else                  rd_q[15:0]  <= cap_dat;
            end else if (launch) begin
                cyc_q <= 1'b1;
                we_q  <= ~cmd_q.rd;
                if (state_q == ST_HI) begin
                    adr_q <= {cmd_q.dw, 1'b1};
                    sel_q <= cmd_q.be[3:2];
                    dat_q <= cmd_q.wd[31:16];
                end else begin
                    adr_q <= {cmd_q.dw, 1'b0};
                    sel_q <= cmd_q.be[1:0];
                    dat_q <= cmd_q.wd[15:0];
                end
            end
        end
    end

    always_comb begin
        avs_waitrequest   = (state_q != ST_IDLE) | wb_rst_i;
        avs_readdatavalid = (state_q == ST_RESP) & ~wb_rst_i;
        avs_readdata      = avs_readdatavalid ? rd_q : 32'h0;
    end

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_adr_o = adr_q;
    assign wbm_sel_o = sel_q;
    assign wbm_dat_o = dat_q;

endmodule
